// File: rtl/mcpu_boot_ctrl.sv
// Boot/debug controller: gives the host exclusive access to the CPU memory while the
// CPU is halted in reset, and releases the CPU for bounded or unbounded RUN periods.
module mcpu_boot_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [5:0]  cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  input  logic        run,
  input  logic [15:0] step_limit,
  output logic        running,
  output logic        done,
  output logic [15:0] cycle_count,
  output logic        cpu_rst_n,
  input  logic [5:0]  cpu_adress,
  input  logic        cpu_oe,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [5:0]  mem_adress,
  output logic        mem_oe,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_HWR  = 2'd1,
    S_HRD  = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_halt;
  logic        r_running;
  logic        r_done;
  logic        r_rsp_valid;
  logic [7:0]  r_rsp_data;
  logic [5:0]  r_addr;
  logic [7:0]  r_wdata;
  logic [15:0] r_limit;
  logic [15:0] r_cycle_count;
  logic        w_accept;
  logic        w_limit_hit;

  assign w_accept    = (r_state == S_HALT) && cmd_valid;
  // Compared one bit wider so a saturated counter can never alias onto the limit.
  assign w_limit_hit = (r_state == S_RUN) && (r_limit != 16'd0) &&
                       (({1'b0, r_cycle_count} + 17'd1) == {1'b0, r_limit});

  // Next-state selection; a host command in HALT outranks a run request.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HALT: begin
        if (w_accept) begin
          w_next = cmd_write ? S_HWR : S_HRD;
        end else if (run) begin
          w_next = S_RUN;
        end else begin
          w_next = S_HALT;
        end
      end
      S_HWR:  w_next = S_HALT;
      S_HRD:  w_next = S_HALT;
      S_RUN: begin
        if (w_limit_hit || !run) begin
          w_next = S_HALT;
        end else begin
          w_next = S_RUN;
        end
      end
      default: w_next = S_HALT;
    endcase
  end

  // Memory port steering: host-latched values outside RUN, CPU bus pass-through in RUN.
  always_comb begin
    mem_adress = r_addr;
    mem_wdata  = r_wdata;
    mem_oe     = 1'b1;
    mem_we     = 1'b1;
    case (r_state)
      S_HALT: begin
        mem_oe = 1'b1;
        mem_we = 1'b1;
      end
      S_HWR:  mem_we = 1'b0;
      S_HRD:  mem_oe = 1'b0;
      S_RUN: begin
        mem_adress = cpu_adress;
        mem_wdata  = cpu_wdata;
        mem_oe     = cpu_oe;
        mem_we     = cpu_we;
      end
      default: begin
        mem_oe = 1'b1;
        mem_we = 1'b1;
      end
    endcase
  end

  // State register plus flag registers decoded from the next state so they never glitch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_HALT;
      r_halt        <= 1'b1;
      r_running     <= 1'b0;
      r_done        <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= 8'h00;
      r_addr        <= 6'h00;
      r_wdata       <= 8'h00;
      r_limit       <= 16'h0000;
      r_cycle_count <= 16'h0000;
    end else begin
      r_state     <= w_next;
      r_halt      <= (w_next == S_HALT);
      r_running   <= (w_next == S_RUN);
      r_done      <= w_limit_hit;
      r_rsp_valid <= (r_state == S_HRD);
      if (r_state == S_HRD) begin
        r_rsp_data <= mem_rdata;
      end
      if (w_accept) begin
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
      end
      if ((r_state == S_HALT) && (w_next == S_RUN)) begin
        r_cycle_count <= 16'h0000;
        r_limit       <= step_limit;
      end else if ((r_state == S_RUN) && (r_cycle_count != 16'hFFFF)) begin
        r_cycle_count <= r_cycle_count + 16'd1;
      end
    end
  end

  assign cmd_ready   = r_halt;
  assign running     = r_running;
  assign cpu_rst_n   = r_running;
  assign done        = r_done;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign cycle_count = r_cycle_count;
  assign cpu_rdata   = mem_rdata;

endmodule

// File: tb/tb_mcpu_boot_ctrl.sv
// Directed bench for mcpu_boot_ctrl: per-cycle vector table against a 64x8 memory model,
// followed by a hand-written command-versus-run priority sequence.
module tb_mcpu_boot_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [5:0]  cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        run;
  logic [15:0] step_limit;
  logic        running;
  logic        done;
  logic [15:0] cycle_count;
  logic        cpu_rst_n;
  logic [5:0]  cpu_adress;
  logic        cpu_oe;
  logic        cpu_we;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic [5:0]  mem_adress;
  logic        mem_oe;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:63];
  int          errors;
  int          checks;

  mcpu_boot_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .run(run), .step_limit(step_limit), .running(running), .done(done),
    .cycle_count(cycle_count), .cpu_rst_n(cpu_rst_n),
    .cpu_adress(cpu_adress), .cpu_oe(cpu_oe), .cpu_we(cpu_we),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .mem_adress(mem_adress), .mem_oe(mem_oe), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_adress];

  // Memory model: synchronous write while the active-low write enable is low.
  always @(posedge clk) begin
    if (mem_we === 1'b0) mem[mem_adress] <= mem_wdata;
  end

  typedef struct {
    logic        rst, cv, cw;
    logic [5:0]  ca;
    logic [7:0]  cd;
    logic        rn;
    logic [15:0] lim;
    logic [5:0]  pa;
    logic        pwe;
    logic [7:0]  pd;
    logic        rdy, rng, dn, rv;
    logic [7:0]  rd;
    logic [15:0] cc;
    logic        mwe, moe;
    logic [5:0]  ma;
  } vec_t;

  vec_t tbl[$];

  task automatic t(input logic r, input logic cv, input logic cw, input logic [5:0] ca,
                   input logic [7:0] cd, input logic rn, input logic [15:0] lim,
                   input logic [5:0] pa, input logic pwe, input logic [7:0] pd,
                   input logic rdy, input logic rng, input logic dn, input logic rv,
                   input logic [7:0] rd, input logic [15:0] cc, input logic mwe,
                   input logic moe, input logic [5:0] ma);
    vec_t v;
    v.rst = r; v.cv = cv; v.cw = cw; v.ca = ca; v.cd = cd; v.rn = rn; v.lim = lim;
    v.pa = pa; v.pwe = pwe; v.pd = pd; v.rdy = rdy; v.rng = rng; v.dn = dn; v.rv = rv;
    v.rd = rd; v.cc = cc; v.mwe = mwe; v.moe = moe; v.ma = ma;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    logic [36:0] got_v;
    logic [36:0] exp_v;
    int          n;
    errors = 0;
    checks = 0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 6'h00; cmd_wdata = 8'h00;
    run = 1'b0; step_limit = 16'd0; cpu_adress = 6'h00; cpu_oe = 1'b1; cpu_we = 1'b1;
    cpu_wdata = 8'h00;

    // rst cv cw ca cd run lim | cpu a we d | rdy running done rv rd cc mwe moe ma
    t(1'b1,1'b0,1'b0,6'h00,8'h00,1'b0,16'd0, 6'h00,1'b1,8'h00, 1'b1,1'b0,1'b0,1'b0,8'h00,16'd0, 1'b1,1'b1,6'h00);
    t(1'b1,1'b1,1'b1,6'h05,8'hA7,1'b0,16'd0, 6'h00,1'b1,8'h00, 1'b1,1'b0,1'b0,1'b0,8'h00,16'd0, 1'b1,1'b1,6'h00);
    t(1'b1,1'b0,1'b0,6'h00,8'h00,1'b0,16'd0, 6'h00,1'b1,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h00,16'd0, 1'b0,1'b1,6'h05);
    t(1'b1,1'b1,1'b0,6'h05,8'h00,1'b0,16'd0, 6'h00,1'b1,8'h00, 1'b1,1'b0,1'b0,1'b0,8'h00,16'd0, 1'b1,1'b1,6'h05);
    t(1'b1,1'b0,1'b0,6'h00,8'h00,1'b0,16'd0, 6'h00,1'b1,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h00,16'd0, 1'b1,1'b0,6'h05);
    t(1'b1,1'b0,1'b0,6'h00,8'h00,1'b0,16'd0, 6'h00,1'b1,8'h00, 1'b1,1'b0,1'b0,1'b1,8'hA7,16'd0, 1'b1,1'b1,6'h05);
    t(1'b1,1'b0,1'b0,6'h00,8'h00,1'b0,16'd0, 6'h00,1'b1,8'h00, 1'b1,1'b0,1'b0,1'b0,8'hA7,16'd0, 1'b1,1'b1,6'h05);
    // Limit 3, with a read command held pending through RUN.
    t(1'b1,1'b0,1'b0,6'h00,8'h00,1'b1,16'd3, 6'h00,1'b1,8'h00, 1'b1,1'b0,1'b0,1'b0,8'hA7,16'd0, 1'b1,1'b1,6'h05);
    t(1'b1,1'b1,1'b0,6'h2A,8'h00,1'b1,16'd0, 6'h2A,1'b0,8'h3C, 1'b0,1'b1,1'b0,1'b0,8'hA7,16'd0, 1'b0,1'b1,6'h2A);
    t(1'b1,1'b1,1'b0,6'h2A,8'h00,1'b1,16'd0, 6'h00,1'b1,8'h00, 1'b0,1'b1,1'b0,1'b0,8'hA7,16'd1, 1'b1,1'b1,6'h00);
    t(1'b1,1'b1,1'b0,6'h2A,8'h00,1'b1,16'd0, 6'h00,1'b1,8'h00, 1'b0,1'b1,1'b0,1'b0,8'hA7,16'd2, 1'b1,1'b1,6'h00);
    t(1'b1,1'b1,1'b0,6'h2A,8'h00,1'b1,16'd0, 6'h00,1'b1,8'h00, 1'b1,1'b0,1'b1,1'b0,8'hA7,16'd3, 1'b1,1'b1,6'h05);
    t(1'b1,1'b0,1'b0,6'h00,8'h00,1'b1,16'd0, 6'h00,1'b1,8'h00, 1'b0,1'b0,1'b0,1'b0,8'hA7,16'd3, 1'b1,1'b0,6'h2A);
    t(1'b1,1'b0,1'b0,6'h00,8'h00,1'b1,16'd0, 6'h00,1'b1,8'h00, 1'b1,1'b0,1'b0,1'b1,8'h3C,16'd3, 1'b1,1'b1,6'h2A);
    // Unlimited run for 10 cycles.
    for (int k = 0; k < 9; k++)
      t(1'b1,1'b0,1'b0,6'h00,8'h00,1'b1,16'd0, 6'h00,1'b1,8'h00, 1'b0,1'b1,1'b0,1'b0,8'h3C,16'(k), 1'b1,1'b1,6'h00);
    t(1'b1,1'b0,1'b0,6'h00,8'h00,1'b0,16'd0, 6'h00,1'b1,8'h00, 1'b0,1'b1,1'b0,1'b0,8'h3C,16'd9, 1'b1,1'b1,6'h00);
    t(1'b1,1'b0,1'b0,6'h00,8'h00,1'b0,16'd0, 6'h00,1'b1,8'h00, 1'b1,1'b0,1'b0,1'b0,8'h3C,16'd10,1'b1,1'b1,6'h2A);
    t(1'b1,1'b0,1'b0,6'h00,8'h00,1'b0,16'd0, 6'h00,1'b1,8'h00, 1'b1,1'b0,1'b0,1'b0,8'h3C,16'd10,1'b1,1'b1,6'h2A);
    // Limit 1 restart, then limit beats run=0 in the same cycle.
    t(1'b1,1'b0,1'b0,6'h00,8'h00,1'b1,16'd1, 6'h00,1'b1,8'h00, 1'b1,1'b0,1'b0,1'b0,8'h3C,16'd10,1'b1,1'b1,6'h2A);
    t(1'b1,1'b0,1'b0,6'h00,8'h00,1'b1,16'd1, 6'h00,1'b1,8'h00, 1'b0,1'b1,1'b0,1'b0,8'h3C,16'd0, 1'b1,1'b1,6'h00);
    t(1'b1,1'b0,1'b0,6'h00,8'h00,1'b1,16'd1, 6'h00,1'b1,8'h00, 1'b1,1'b0,1'b1,1'b0,8'h3C,16'd1, 1'b1,1'b1,6'h2A);
    t(1'b1,1'b0,1'b0,6'h00,8'h00,1'b0,16'd0, 6'h00,1'b1,8'h00, 1'b0,1'b1,1'b0,1'b0,8'h3C,16'd0, 1'b1,1'b1,6'h00);
    t(1'b1,1'b0,1'b0,6'h00,8'h00,1'b0,16'd0, 6'h00,1'b1,8'h00, 1'b1,1'b0,1'b1,1'b0,8'h3C,16'd1, 1'b1,1'b1,6'h2A);
    t(1'b1,1'b0,1'b0,6'h00,8'h00,1'b0,16'd0, 6'h00,1'b1,8'h00, 1'b1,1'b0,1'b0,1'b0,8'h3C,16'd1, 1'b1,1'b1,6'h2A);
    // Reset during HRD aborts the read.
    t(1'b1,1'b1,1'b0,6'h05,8'h00,1'b0,16'd0, 6'h00,1'b1,8'h00, 1'b1,1'b0,1'b0,1'b0,8'h3C,16'd1, 1'b1,1'b1,6'h2A);
    t(1'b0,1'b0,1'b0,6'h00,8'h00,1'b0,16'd0, 6'h00,1'b1,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h3C,16'd1, 1'b1,1'b0,6'h05);
    t(1'b1,1'b0,1'b0,6'h00,8'h00,1'b0,16'd0, 6'h00,1'b1,8'h00, 1'b1,1'b0,1'b0,1'b0,8'h00,16'd0, 1'b1,1'b1,6'h00);
    t(1'b1,1'b0,1'b0,6'h00,8'h00,1'b0,16'd0, 6'h00,1'b1,8'h00, 1'b1,1'b0,1'b0,1'b0,8'h00,16'd0, 1'b1,1'b1,6'h00);

    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; cmd_valid = tbl[i].cv; cmd_write = tbl[i].cw; cmd_addr = tbl[i].ca;
      cmd_wdata = tbl[i].cd; run = tbl[i].rn; step_limit = tbl[i].lim;
      cpu_adress = tbl[i].pa; cpu_we = tbl[i].pwe; cpu_wdata = tbl[i].pd;
      #1;
      got_v = {cmd_ready, running, cpu_rst_n, done, rsp_valid, rsp_data, cycle_count,
               mem_we, mem_oe, mem_adress};
      exp_v = {tbl[i].rdy, tbl[i].rng, tbl[i].rng, tbl[i].dn, tbl[i].rv, tbl[i].rd,
               tbl[i].cc, tbl[i].mwe, tbl[i].moe, tbl[i].ma};
      check($sformatf("vec%0d rdy/run/rstn/done/rv/rd/cc/we/oe/addr", i), 64'(got_v), 64'(exp_v));
      check($sformatf("vec%0d cpu_rdata", i), 64'(cpu_rdata), 64'(mem[mem_adress]));
    end

    // Write command and run request presented together: write first, then RUN.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h3F; cmd_wdata = 8'h5A;
    run = 1'b1; step_limit = 16'd0;
    #1;
    check("prio accept ready", 64'(cmd_ready), 64'(1'b1));
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    check("prio hwr we/running/wdata", 64'({mem_we, running, mem_adress, mem_wdata}),
          64'({1'b0, 1'b0, 6'h3F, 8'h5A}));
    n = 0;
    while (!running && n < 8) begin
      @(negedge clk);
      n++;
      #1;
    end
    check("prio cycles to RUN", 64'(n), 64'(2));
    check("prio mem[3F] written", 64'(mem[63]), 64'(8'h5A));
    run = 1'b0;
    @(negedge clk);
    #1;
    check("prio exit running/done/cc", 64'({running, done, cycle_count}),
          64'({1'b0, 1'b0, 16'd1}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
